// File: rtl/bolme_denetleyici_pkg.sv
// ============================================================================
// Module   : bolme_denetleyici_pkg
// Purpose  : Shared op codes, FSM state encoding and op-decode helpers for
//            the divider sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bolme_denetleyici_pkg;

   localparam int SOZCUK_GENISLIGI_BIT = 32;

   localparam logic [1:0] ISLEM_DIV  = 2'b00;
   localparam logic [1:0] ISLEM_DIVU = 2'b01;
   localparam logic [1:0] ISLEM_REM  = 2'b10;
   localparam logic [1:0] ISLEM_REMU = 2'b11;

   typedef enum logic [2:0] {
      BOS    = 3'd0,
      BASLAT = 3'd1,
      BEKLE  = 3'd2,
      SONUC  = 3'd3,
      BOSALT = 3'd4
   } durum_t;

   function automatic logic isaretli(input logic [1:0] islem);
      return (islem == ISLEM_DIV) || (islem == ISLEM_REM);
   endfunction

   function automatic logic kalan_secili(input logic [1:0] islem);
      return (islem == ISLEM_REM) || (islem == ISLEM_REMU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bolme_denetleyici_onbellek.sv
// ============================================================================
// Module   : bolme_denetleyici_onbellek
// Purpose  : Last-operand result store; flags a hit when a new request
//            repeats the previous operands and signedness.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bolme_denetleyici_onbellek
   import bolme_denetleyici_pkg::*;
#(
   parameter int SOZCUK_GENISLIGI = SOZCUK_GENISLIGI_BIT,
   parameter bit AKTIF            = 1'b1
) (
   input  logic                        i_clk,
   input  logic                        i_rstn,
   input  logic                        i_yaz,
   input  logic [SOZCUK_GENISLIGI-1:0] i_yaz_bolunen,
   input  logic [SOZCUK_GENISLIGI-1:0] i_yaz_bolen,
   input  logic                        i_yaz_isaretli,
   input  logic [SOZCUK_GENISLIGI-1:0] i_yaz_bolum,
   input  logic [SOZCUK_GENISLIGI-1:0] i_yaz_kalan,
   input  logic [SOZCUK_GENISLIGI-1:0] i_sor_bolunen,
   input  logic [SOZCUK_GENISLIGI-1:0] i_sor_bolen,
   input  logic                        i_sor_isaretli,
   output logic                        o_isabet,
   output logic [SOZCUK_GENISLIGI-1:0] o_bolum,
   output logic [SOZCUK_GENISLIGI-1:0] o_kalan
);

   generate
      if (AKTIF) begin : g_onbellek
         logic                        r_gecerli;
         logic [SOZCUK_GENISLIGI-1:0] r_bolunen;
         logic [SOZCUK_GENISLIGI-1:0] r_bolen;
         logic                        r_isaretli;
         logic [SOZCUK_GENISLIGI-1:0] r_bolum;
         logic [SOZCUK_GENISLIGI-1:0] r_kalan;

         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_gecerli  <= 1'b0;
               r_bolunen  <= '0;
               r_bolen    <= '0;
               r_isaretli <= 1'b0;
               r_bolum    <= '0;
               r_kalan    <= '0;
            end else if (i_yaz) begin
               r_gecerli  <= 1'b1;
               r_bolunen  <= i_yaz_bolunen;
               r_bolen    <= i_yaz_bolen;
               r_isaretli <= i_yaz_isaretli;
               r_bolum    <= i_yaz_bolum;
               r_kalan    <= i_yaz_kalan;
            end
         end

         assign o_isabet = r_gecerli && (r_bolunen == i_sor_bolunen) &&
                           (r_bolen == i_sor_bolen) && (r_isaretli == i_sor_isaretli);
         assign o_bolum  = r_bolum;
         assign o_kalan  = r_kalan;
      end else begin : g_onbellek_yok
         assign o_isabet = 1'b0;
         assign o_bolum  = '0;
         assign o_kalan  = '0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/bolme_denetleyici.sv
// ============================================================================
// Module   : bolme_denetleyici
// Purpose  : Execute-stage sequencer for the external multi-cycle divider,
//            with flush, watchdog and last-result reuse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bolme_denetleyici
   import bolme_denetleyici_pkg::*;
#(
   parameter int SOZCUK_GENISLIGI = SOZCUK_GENISLIGI_BIT,
   parameter int ETIKET_GENISLIGI = 5,
   parameter bit ONBELLEK_AKTIF   = 1'b1,
   parameter int ZAMAN_ASIMI      = 40
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic                        gecerli_i,
   output logic                        hazir_o,
   input  logic [1:0]                  islem_i,
   input  logic [SOZCUK_GENISLIGI-1:0] bolunen_i,
   input  logic [SOZCUK_GENISLIGI-1:0] bolen_i,
   input  logic [ETIKET_GENISLIGI-1:0] etiket_i,
   input  logic                        iptal_i,
   output logic                        sonuc_gecerli_o,
   input  logic                        sonuc_hazir_i,
   output logic [SOZCUK_GENISLIGI-1:0] sonuc_o,
   output logic [ETIKET_GENISLIGI-1:0] sonuc_etiket_o,
   output logic                        mesgul_o,
   output logic                        hata_o,
   output logic [SOZCUK_GENISLIGI-1:0] bol_bolunen_o,
   output logic [SOZCUK_GENISLIGI-1:0] bol_bolen_o,
   output logic                        bol_isaretli_o,
   output logic                        bol_basla_o,
   input  logic [SOZCUK_GENISLIGI-1:0] bol_bolum_i,
   input  logic [SOZCUK_GENISLIGI-1:0] bol_kalan_i,
   input  logic                        bol_hazir_i
);

   localparam int c_SAYAC_W = $clog2(ZAMAN_ASIMI + 1);
   localparam logic [c_SAYAC_W-1:0] c_SAYAC_SON = c_SAYAC_W'(ZAMAN_ASIMI - 1);

   durum_t                      r_durum;
   logic [1:0]                  r_islem;
   logic [SOZCUK_GENISLIGI-1:0] r_bolunen;
   logic [SOZCUK_GENISLIGI-1:0] r_bolen;
   logic [ETIKET_GENISLIGI-1:0] r_etiket;
   logic [SOZCUK_GENISLIGI-1:0] r_sonuc;
   logic                        r_hazir;
   logic                        r_sonuc_gecerli;
   logic                        r_basla;
   logic                        r_hata;
   logic [c_SAYAC_W-1:0]        r_sayac;

   logic                        w_kabul;
   logic                        w_isabet;
   logic                        w_onbellek_yaz;
   logic                        w_sure_doldu;
   logic [SOZCUK_GENISLIGI-1:0] w_onb_bolum;
   logic [SOZCUK_GENISLIGI-1:0] w_onb_kalan;

   assign w_kabul        = r_hazir && gecerli_i && !iptal_i;
   assign w_sure_doldu   = (r_sayac == c_SAYAC_SON);
   // A completion that coincides with a flush is dropped, not cached.
   assign w_onbellek_yaz = (r_durum == BEKLE) && bol_hazir_i && !iptal_i;

   bolme_denetleyici_onbellek #(
      .SOZCUK_GENISLIGI (SOZCUK_GENISLIGI),
      .AKTIF            (ONBELLEK_AKTIF)
   ) u_onbellek (
      .i_clk          (clk_i),
      .i_rstn         (rstn_i),
      .i_yaz          (w_onbellek_yaz),
      .i_yaz_bolunen  (r_bolunen),
      .i_yaz_bolen    (r_bolen),
      .i_yaz_isaretli (isaretli(r_islem)),
      .i_yaz_bolum    (bol_bolum_i),
      .i_yaz_kalan    (bol_kalan_i),
      .i_sor_bolunen  (bolunen_i),
      .i_sor_bolen    (bolen_i),
      .i_sor_isaretli (isaretli(islem_i)),
      .o_isabet       (w_isabet),
      .o_bolum        (w_onb_bolum),
      .o_kalan        (w_onb_kalan)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_durum         <= BOS;
         r_islem         <= '0;
         r_bolunen       <= '0;
         r_bolen         <= '0;
         r_etiket        <= '0;
         r_sonuc         <= '0;
         r_hazir         <= 1'b1;
         r_sonuc_gecerli <= 1'b0;
         r_basla         <= 1'b0;
         r_hata          <= 1'b0;
         r_sayac         <= '0;
      end else begin
         case (r_durum)
            BOS: begin
               if (w_kabul) begin
                  r_islem   <= islem_i;
                  r_bolunen <= bolunen_i;
                  r_bolen   <= bolen_i;
                  r_etiket  <= etiket_i;
                  r_hazir   <= 1'b0;
                  if (w_isabet) begin
                     r_sonuc         <= kalan_secili(islem_i) ? w_onb_kalan : w_onb_bolum;
                     r_sonuc_gecerli <= 1'b1;
                     r_durum         <= SONUC;
                  end else begin
                     r_basla <= 1'b1;
                     r_durum <= BASLAT;
                  end
               end
            end
            BASLAT: begin
               r_basla <= 1'b0;
               r_sayac <= '0;
               r_durum <= iptal_i ? BOSALT : BEKLE;
            end
            BEKLE: begin
               if (bol_hazir_i) begin
                  if (iptal_i) begin
                     r_hazir <= 1'b1;
                     r_durum <= BOS;
                  end else begin
                     r_sonuc         <= kalan_secili(r_islem) ? bol_kalan_i : bol_bolum_i;
                     r_sonuc_gecerli <= 1'b1;
                     r_durum         <= SONUC;
                  end
               end else if (w_sure_doldu) begin
                  r_hata  <= 1'b1;
                  r_hazir <= 1'b1;
                  r_durum <= BOS;
               end else begin
                  r_sayac <= r_sayac + c_SAYAC_W'(1);
                  if (iptal_i) begin
                     r_durum <= BOSALT;
                  end
               end
            end
            BOSALT: begin
               // The divider ignores start while busy, so let it finish first.
               if (bol_hazir_i) begin
                  r_hazir <= 1'b1;
                  r_durum <= BOS;
               end else if (w_sure_doldu) begin
                  r_hata  <= 1'b1;
                  r_hazir <= 1'b1;
                  r_durum <= BOS;
               end else begin
                  r_sayac <= r_sayac + c_SAYAC_W'(1);
               end
            end
            SONUC: begin
               if (iptal_i || sonuc_hazir_i) begin
                  r_sonuc_gecerli <= 1'b0;
                  r_hazir         <= 1'b1;
                  r_durum         <= BOS;
               end
            end
            default: begin
               r_basla         <= 1'b0;
               r_sonuc_gecerli <= 1'b0;
               r_hazir         <= 1'b1;
               r_durum         <= BOS;
            end
         endcase
      end
   end

   assign hazir_o         = r_hazir;
   assign sonuc_gecerli_o = r_sonuc_gecerli;
   assign sonuc_o         = r_sonuc;
   assign sonuc_etiket_o  = r_etiket;
   assign mesgul_o        = (r_durum != BOS);
   assign hata_o          = r_hata;
   assign bol_bolunen_o   = r_bolunen;
   assign bol_bolen_o     = r_bolen;
   assign bol_isaretli_o  = isaretli(r_islem);
   assign bol_basla_o     = r_basla;

endmodule

`default_nettype wire

// File: tb/tb_bolme_denetleyici.sv
// ============================================================================
// Module   : tb_bolme_denetleyici
// Purpose  : Directed self-checking bench with a latency-programmable
//            divider model answering the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bolme_denetleyici;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        gecerli_i;
   logic        hazir_o;
   logic [1:0]  islem_i;
   logic [31:0] bolunen_i;
   logic [31:0] bolen_i;
   logic [4:0]  etiket_i;
   logic        iptal_i;
   logic        sonuc_gecerli_o;
   logic        sonuc_hazir_i;
   logic [31:0] sonuc_o;
   logic [4:0]  sonuc_etiket_o;
   logic        mesgul_o;
   logic        hata_o;
   logic [31:0] bol_bolunen_o;
   logic [31:0] bol_bolen_o;
   logic        bol_isaretli_o;
   logic        bol_basla_o;
   logic [31:0] bol_bolum_i;
   logic [31:0] bol_kalan_i;
   logic        bol_hazir_i;

   int n_kontrol = 0;
   int n_hata    = 0;
   int gecikme   = 3;
   int basla_sayisi = 0;
   int hazir_sayisi = 0;
   logic mdl_mesgul;
   int   mdl_sayac;

   bolme_denetleyici dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .gecerli_i       (gecerli_i),
      .hazir_o         (hazir_o),
      .islem_i         (islem_i),
      .bolunen_i       (bolunen_i),
      .bolen_i         (bolen_i),
      .etiket_i        (etiket_i),
      .iptal_i         (iptal_i),
      .sonuc_gecerli_o (sonuc_gecerli_o),
      .sonuc_hazir_i   (sonuc_hazir_i),
      .sonuc_o         (sonuc_o),
      .sonuc_etiket_o  (sonuc_etiket_o),
      .mesgul_o        (mesgul_o),
      .hata_o          (hata_o),
      .bol_bolunen_o   (bol_bolunen_o),
      .bol_bolen_o     (bol_bolen_o),
      .bol_isaretli_o  (bol_isaretli_o),
      .bol_basla_o     (bol_basla_o),
      .bol_bolum_i     (bol_bolum_i),
      .bol_kalan_i     (bol_kalan_i),
      .bol_hazir_i     (bol_hazir_i)
   );

   always #5 clk_i = ~clk_i;

   // Divider model: results follow the operand outputs combinationally;
   // completion pulses 'gecikme' cycles after the start pulse is seen.
   always_comb begin
      if (bol_bolen_o == 32'd0) begin
         bol_bolum_i = 32'hFFFF_FFFF;
         bol_kalan_i = bol_bolunen_o;
      end else if (bol_isaretli_o && bol_bolunen_o == 32'h8000_0000 && bol_bolen_o == 32'hFFFF_FFFF) begin
         bol_bolum_i = 32'h8000_0000;
         bol_kalan_i = 32'd0;
      end else if (bol_isaretli_o) begin
         bol_bolum_i = $signed(bol_bolunen_o) / $signed(bol_bolen_o);
         bol_kalan_i = $signed(bol_bolunen_o) % $signed(bol_bolen_o);
      end else begin
         bol_bolum_i = bol_bolunen_o / bol_bolen_o;
         bol_kalan_i = bol_bolunen_o % bol_bolen_o;
      end
   end

   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mdl_mesgul  <= 1'b0;
         mdl_sayac   <= 0;
         bol_hazir_i <= 1'b0;
      end else begin
         bol_hazir_i <= 1'b0;
         if (mdl_mesgul) begin
            if (mdl_sayac <= 1) begin
               bol_hazir_i <= 1'b1;
               mdl_mesgul  <= 1'b0;
            end else begin
               mdl_sayac <= mdl_sayac - 1;
            end
         end else if (bol_basla_o) begin
            if (gecikme == 0) begin
               bol_hazir_i <= 1'b1;
            end else begin
               mdl_mesgul <= 1'b1;
               mdl_sayac  <= gecikme;
            end
         end
      end
   end

   always @(posedge clk_i) begin
      if (bol_basla_o) basla_sayisi <= basla_sayisi + 1;
      if (bol_hazir_i) hazir_sayisi <= hazir_sayisi + 1;
   end

   task automatic islem_gonder(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] t);
      int n = 0;
      while (!hazir_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      gecerli_i = 1'b1;
      islem_i   = op;
      bolunen_i = a;
      bolen_i   = b;
      etiket_i  = t;
      @(negedge clk_i);
      gecerli_i = 1'b0;
   endtask

   task automatic sonuc_bekle(output logic [31:0] s, output logic [4:0] t, output int cyc,
                              output bit zaman);
      cyc = 0;
      while (!sonuc_gecerli_o && cyc < 200) begin
         @(negedge clk_i);
         cyc++;
      end
      zaman = !sonuc_gecerli_o;
      s = sonuc_o;
      t = sonuc_etiket_o;
   endtask

   task automatic sonuc_al();
      sonuc_hazir_i = 1'b1;
      @(negedge clk_i);
      sonuc_hazir_i = 1'b0;
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      repeat (3) @(negedge clk_i);
      n_kontrol++;
      if ({hazir_o, sonuc_gecerli_o, bol_basla_o, hata_o, mesgul_o} !== 5'b10000 || sonuc_o !== 32'd0) begin
         n_hata++;
         $display("FAIL reset_held: flags=%b sonuc=%h required flags=10000 sonuc=0",
                  {hazir_o, sonuc_gecerli_o, bol_basla_o, hata_o, mesgul_o}, sonuc_o);
      end
      rstn_i = 1'b1;
      @(negedge clk_i);
      n_kontrol++;
      if ({hazir_o, sonuc_gecerli_o, bol_basla_o, hata_o, mesgul_o} !== 5'b10000 || bol_bolunen_o !== 32'd0) begin
         n_hata++;
         $display("FAIL reset_release: flags=%b bolunen=%h required flags=10000 bolunen=0",
                  {hazir_o, sonuc_gecerli_o, bol_basla_o, hata_o, mesgul_o}, bol_bolunen_o);
      end
   endtask

   task automatic test_onbellek_ciftleri();
      logic [31:0] s; logic [4:0] t; int cyc; bit z; int b0;
      gecikme = 3;
      b0 = basla_sayisi;
      islem_gonder(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'hFFFF_FFFD || cyc != 5) begin
         n_hata++;
         $display("FAIL div_m7_2: sonuc=%h cyc=%0d required FFFFFFFD cyc=5", s, cyc);
      end
      sonuc_al();
      n_kontrol++;
      if (basla_sayisi != b0 + 1) begin
         n_hata++;
         $display("FAIL div_m7_2_start: pulses=%0d required %0d", basla_sayisi - b0, 1);
      end
      islem_gonder(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'hFFFF_FFFF || cyc != 0 || t !== 5'd2) begin
         n_hata++;
         $display("FAIL rem_m7_2_hit: sonuc=%h cyc=%0d tag=%0d required FFFFFFFF cyc=0 tag=2", s, cyc, t);
      end
      sonuc_al();
      n_kontrol++;
      if (basla_sayisi != b0 + 1) begin
         n_hata++;
         $display("FAIL rem_hit_no_start: pulses=%0d required %0d", basla_sayisi - b0, 1);
      end
   endtask

   task automatic test_isaretsiz_etiket();
      logic [31:0] s; logic [4:0] t; int cyc; bit z;
      gecikme = 4;
      islem_gonder(2'b01, 32'd100, 32'd7, 5'd3);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'd14 || t !== 5'd3) begin
         n_hata++;
         $display("FAIL divu_100_7: sonuc=%0d tag=%0d required 14 tag=3", s, t);
      end
      sonuc_al();
      islem_gonder(2'b11, 32'd100, 32'd7, 5'd4);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'd2 || t !== 5'd4) begin
         n_hata++;
         $display("FAIL remu_100_7: sonuc=%0d tag=%0d required 2 tag=4", s, t);
      end
      sonuc_al();
   endtask

   task automatic test_sinir_durumlari();
      logic [31:0] s; logic [4:0] t; int cyc; bit z;
      gecikme = 0;
      islem_gonder(2'b01, 32'd5, 32'd0, 5'd5);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'hFFFF_FFFF || cyc != 2) begin
         n_hata++;
         $display("FAIL divu_5_0: sonuc=%h cyc=%0d required FFFFFFFF cyc=2", s, cyc);
      end
      sonuc_al();
      islem_gonder(2'b10, 32'd5, 32'd0, 5'd6);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'd5) begin
         n_hata++;
         $display("FAIL rem_5_0: sonuc=%h required 00000005", s);
      end
      sonuc_al();
      islem_gonder(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'h8000_0000) begin
         n_hata++;
         $display("FAIL div_min_m1: sonuc=%h required 80000000", s);
      end
      sonuc_al();
   endtask

   task automatic test_iptal_bekle();
      logic [31:0] s; logic [4:0] t; int cyc; bit z; int h0; int b0; int n; bit gorulen;
      gecikme = 20;
      h0 = hazir_sayisi;
      islem_gonder(2'b01, 32'hFFFF_FFFF, 32'd3, 5'd8);
      repeat (10) @(negedge clk_i);
      n_kontrol++;
      if (hazir_o !== 1'b0 || mesgul_o !== 1'b1) begin
         n_hata++;
         $display("FAIL flush_busy: hazir=%b mesgul=%b required 0 1", hazir_o, mesgul_o);
      end
      iptal_i = 1'b1;
      @(negedge clk_i);
      iptal_i = 1'b0;
      gorulen = 1'b0;
      n = 0;
      while (!hazir_o && n < 60) begin
         if (sonuc_gecerli_o) gorulen = 1'b1;
         @(negedge clk_i);
         n++;
      end
      n_kontrol++;
      if (gorulen || sonuc_gecerli_o !== 1'b0) begin
         n_hata++;
         $display("FAIL flush_no_result: valid_seen=%b required 0", gorulen);
      end
      n_kontrol++;
      if (hazir_o !== 1'b1 || hazir_sayisi == h0) begin
         n_hata++;
         $display("FAIL flush_drain: hazir=%b completions=%0d required hazir=1 after completion",
                  hazir_o, hazir_sayisi - h0);
      end
      gecikme = 3;
      b0 = basla_sayisi;
      islem_gonder(2'b00, 32'd9, 32'd3, 5'd9);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'd3 || t !== 5'd9 || basla_sayisi != b0 + 1) begin
         n_hata++;
         $display("FAIL div_9_3_after_flush: sonuc=%0d tag=%0d required 3 tag=9", s, t);
      end
      sonuc_al();
   endtask

   task automatic test_geri_basinc();
      logic [31:0] s; logic [4:0] t; int cyc; bit z;
      gecikme = 2;
      islem_gonder(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd10);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'hFFFF_FFF2) begin
         n_hata++;
         $display("FAIL div_100_m7: sonuc=%h required FFFFFFF2", s);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         n_kontrol++;
         if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'hFFFF_FFF2 || sonuc_etiket_o !== 5'd10 || hazir_o !== 1'b0) begin
            n_hata++;
            $display("FAIL stall_hold_%0d: valid=%b sonuc=%h tag=%0d hazir=%b required 1 FFFFFFF2 10 0",
                     i, sonuc_gecerli_o, sonuc_o, sonuc_etiket_o, hazir_o);
         end
      end
      sonuc_al();
      n_kontrol++;
      if (sonuc_gecerli_o !== 1'b0 || hazir_o !== 1'b1) begin
         n_hata++;
         $display("FAIL stall_release: valid=%b hazir=%b required 0 1", sonuc_gecerli_o, hazir_o);
      end
   endtask

   task automatic test_iptal_sonuc_bos();
      logic [31:0] s; logic [4:0] t; int cyc; bit z;
      islem_gonder(2'b10, 32'd100, 32'hFFFF_FFF9, 5'd11);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'd2 || cyc != 0) begin
         n_hata++;
         $display("FAIL rem_100_m7_hit: sonuc=%h cyc=%0d required 00000002 cyc=0", s, cyc);
      end
      iptal_i = 1'b1;
      @(negedge clk_i);
      iptal_i = 1'b0;
      n_kontrol++;
      if (sonuc_gecerli_o !== 1'b0 || hazir_o !== 1'b1) begin
         n_hata++;
         $display("FAIL flush_in_result: valid=%b hazir=%b required 0 1", sonuc_gecerli_o, hazir_o);
      end
      gecerli_i = 1'b1;
      iptal_i   = 1'b1;
      @(negedge clk_i);
      gecerli_i = 1'b0;
      iptal_i   = 1'b0;
      n_kontrol++;
      if (mesgul_o !== 1'b0 || hazir_o !== 1'b1) begin
         n_hata++;
         $display("FAIL flush_blocks_accept: mesgul=%b hazir=%b required 0 1", mesgul_o, hazir_o);
      end
   endtask

   task automatic test_zaman_asimi();
      int n;
      gecikme = 100;
      islem_gonder(2'b01, 32'd1, 32'd1, 5'd12);
      n = 0;
      while (!hata_o && n < 60) begin
         @(negedge clk_i);
         n++;
         if (n == 30) begin
            n_kontrol++;
            if (hata_o !== 1'b0) begin
               n_hata++;
               $display("FAIL watchdog_early: hata=%b at cycle 30 required 0", hata_o);
            end
         end
      end
      n_kontrol++;
      if (hata_o !== 1'b1 || n < 40 || n > 42) begin
         n_hata++;
         $display("FAIL watchdog_fire: hata=%b cycle=%0d required 1 at 40..42", hata_o, n);
      end
      repeat (3) @(negedge clk_i);
      n_kontrol++;
      if (hata_o !== 1'b1 || hazir_o !== 1'b1 || sonuc_gecerli_o !== 1'b0) begin
         n_hata++;
         $display("FAIL watchdog_sticky: hata=%b hazir=%b valid=%b required 1 1 0", hata_o, hazir_o, sonuc_gecerli_o);
      end
   endtask

   task automatic test_asenkron_reset();
      logic [31:0] s; logic [4:0] t; int cyc; bit z; int b0;
      rstn_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      n_kontrol++;
      if (hata_o !== 1'b0) begin
         n_hata++;
         $display("FAIL reset_clears_hata: hata=%b required 0", hata_o);
      end
      gecikme = 2;
      islem_gonder(2'b00, 32'd50, 32'd5, 5'd13);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'd10) begin
         n_hata++;
         $display("FAIL div_50_5: sonuc=%0d required 10", s);
      end
      sonuc_al();
      gecikme = 10;
      islem_gonder(2'b01, 32'd60, 32'd4, 5'd14);
      repeat (4) @(negedge clk_i);
      rstn_i = 1'b0;
      #1;
      n_kontrol++;
      if ({hazir_o, sonuc_gecerli_o, bol_basla_o, hata_o, mesgul_o} !== 5'b10000 || bol_bolunen_o !== 32'd0) begin
         n_hata++;
         $display("FAIL async_reset: flags=%b bolunen=%h required flags=10000 bolunen=0",
                  {hazir_o, sonuc_gecerli_o, bol_basla_o, hata_o, mesgul_o}, bol_bolunen_o);
      end
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);
      gecikme = 2;
      b0 = basla_sayisi;
      islem_gonder(2'b10, 32'd50, 32'd5, 5'd15);
      sonuc_bekle(s, t, cyc, z);
      n_kontrol++;
      if (z || s !== 32'd0 || basla_sayisi != b0 + 1) begin
         n_hata++;
         $display("FAIL rem_50_5_miss: sonuc=%0d pulses=%0d required 0 pulses=1", s, basla_sayisi - b0);
      end
      sonuc_al();
   endtask

   initial begin
      rstn_i = 1'b0;
      gecerli_i = 1'b0;
      islem_i = 2'b00;
      bolunen_i = '0;
      bolen_i = '0;
      etiket_i = '0;
      iptal_i = 1'b0;
      sonuc_hazir_i = 1'b0;
      test_reset();
      test_onbellek_ciftleri();
      test_isaretsiz_etiket();
      test_sinir_durumlari();
      test_iptal_bekle();
      test_geri_basinc();
      test_iptal_sonuc_bos();
      test_zaman_asimi();
      test_asenkron_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule

`default_nettype wire
